// File: rtl/pwm_fade_ctrl_if.sv
// ---------------------------------------------------------------------------
// pwm_fade_ctrl_if
// Configuration write channel of the PWM fade controller: a valid/ready
// handshake carrying a 4-bit register address and a DW-bit data word.
//
// Signals
//   cfg_valid  master -> slave  write request
//   cfg_ready  slave  -> master write accepted when cfg_valid & cfg_ready
//   cfg_addr   master -> slave  register address
//   cfg_data   master -> slave  write data (DW bits)
//
// Modports
//   master : register/config master side
//   slave  : pwm_fade_ctrl side
// ---------------------------------------------------------------------------
interface pwm_fade_ctrl_if #(
    parameter int DW = 8
);
    logic          cfg_valid;
    logic          cfg_ready;
    logic [3:0]    cfg_addr;
    logic [DW-1:0] cfg_data;

    modport master (
        output cfg_valid,
        output cfg_addr,
        output cfg_data,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_addr,
        input  cfg_data,
        output cfg_ready
    );
endinterface

// File: rtl/pwm_fade_ctrl.sv
// ---------------------------------------------------------------------------
// pwm_fade_ctrl
// Fade/ramp controller for NCH PWM channels. Each channel holds a target duty
// and a live duty; the live duty slews toward the target by 'step' once every
// (rate+1) PWM periods. Live duty only changes on a period boundary, so the
// downstream PWM instances never see a glitched period.
//
// Parameters
//   NCH  number of channels (1..8)
//   DW   duty / phase-counter width, PWM period = 2**DW clk cycles
//
// Ports
//   clk       clock
//   rst       synchronous active-high reset
//   cfg       pwm_fade_ctrl_if.slave config write channel
//             addr 0..NCH-1 : target[ch], NCH : step, NCH+1 : rate,
//             anything else accepted and ignored
//   duty      live duty per channel, ch0 in [DW-1:0]
//   busy      bit ch high while duty[ch] != target[ch]
//   sync_out  high in the cycle where the phase counter is 0
//   irq       (only with PWM_FADE_IRQ_EN) one-cycle pulse after all
//             fades complete
//
// Build option
//   PWM_FADE_IRQ_EN : adds the irq output and its logic.
// ---------------------------------------------------------------------------
module pwm_fade_ctrl #(
    parameter int NCH = 4,
    parameter int DW  = 8
) (
    input  logic              clk,
    input  logic              rst,
    pwm_fade_ctrl_if.slave    cfg,
    output logic [NCH*DW-1:0] duty,
    output logic [NCH-1:0]    busy,
    output logic              sync_out
`ifdef PWM_FADE_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam logic [3:0]    ADDR_STEP  = 4'(NCH);
    localparam logic [3:0]    ADDR_RATE  = 4'(NCH + 1);
    localparam logic [DW-1:0] PHASE_LAST = {DW{1'b1}};

    typedef enum logic {IDLE, RAMP} ch_state_t;

    logic [DW-1:0] phase;
    logic [DW-1:0] div;
    logic [DW-1:0] step;
    logic [DW-1:0] rate;
    logic [DW-1:0] target   [NCH];
    logic [DW-1:0] duty_r   [NCH];
    logic [DW-1:0] target_n [NCH];
    logic [DW-1:0] duty_n   [NCH];
    ch_state_t     state    [NCH];

    logic boundary;
    logic wr;
    logic upd;

    // One slew step from cur toward tgt. The distance is taken in DW+1 bits
    // so the result can neither overshoot the target nor wrap around.
    function automatic logic [DW-1:0] slew(input logic [DW-1:0] cur,
                                           input logic [DW-1:0] tgt,
                                           input logic [DW-1:0] stp);
        logic [DW:0] d;
        if (tgt >= cur)
            d = {1'b0, tgt} - {1'b0, cur};
        else
            d = {1'b0, cur} - {1'b0, tgt};
        if (stp == '0 || d <= {1'b0, stp})
            return tgt;
        else if (tgt > cur)
            return cur + stp;
        else
            return cur - stp;
    endfunction

    // Writes are refused in the boundary cycle, so a config write can never
    // land in the same cycle as a duty update.
    assign boundary      = (phase == PHASE_LAST);
    assign cfg.cfg_ready = ~boundary;
    assign wr            = cfg.cfg_valid & ~boundary;
    assign upd           = boundary & (div == rate);

    // Next target/duty per channel. The update uses the registered target;
    // since writes and updates are mutually exclusive that is always current.
    always_comb begin
        for (int ch = 0; ch < NCH; ch++) begin
            target_n[ch] = target[ch];
            duty_n[ch]   = duty_r[ch];
            if (wr && cfg.cfg_addr == 4'(ch))
                target_n[ch] = cfg.cfg_data;
            if (upd)
                duty_n[ch] = slew(duty_r[ch], target[ch], step);
        end
    end

    // Phase counter, period divider, config registers and per-channel
    // IDLE/RAMP state. sync_out mirrors "phase == 0" one cycle registered,
    // which is why it comes out of reset high: phase is 0 there too.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase    <= '0;
            div      <= '0;
            step     <= DW'(1);
            rate     <= '0;
            sync_out <= 1'b1;
            for (int ch = 0; ch < NCH; ch++) begin
                target[ch] <= '0;
                duty_r[ch] <= '0;
                state[ch]  <= IDLE;
            end
        end else begin
            phase    <= phase + 1'b1;
            sync_out <= boundary;
            if (boundary)
                div <= (div == rate) ? '0 : div + 1'b1;
            if (wr && cfg.cfg_addr == ADDR_STEP)
                step <= cfg.cfg_data;
            if (wr && cfg.cfg_addr == ADDR_RATE) begin
                rate <= cfg.cfg_data;
                div  <= '0;
            end
            for (int ch = 0; ch < NCH; ch++) begin
                target[ch] <= target_n[ch];
                duty_r[ch] <= duty_n[ch];
                state[ch]  <= (duty_n[ch] != target_n[ch]) ? RAMP : IDLE;
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_out
        assign duty[g*DW +: DW] = duty_r[g];
        assign busy[g]          = (state[g] == RAMP);
    end

`ifdef PWM_FADE_IRQ_EN
    logic [NCH-1:0] busy_n;
    logic           irq_arm;

    // Busy pattern that will be visible next cycle.
    always_comb begin
        busy_n = '0;
        for (int ch = 0; ch < NCH; ch++)
            busy_n[ch] = (duty_n[ch] != target_n[ch]);
    end

    // Only an update that finishes the last active fade arms the interrupt;
    // a retarget onto the current duty clears busy without an update and so
    // stays silent. irq follows one cycle after busy reads all-zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_arm <= 1'b0;
            irq     <= 1'b0;
        end else begin
            irq_arm <= upd && (busy != '0) && (busy_n == '0);
            irq     <= irq_arm;
        end
    end
`endif

endmodule
